// File: rtl/vavg_pkg.sv
// Shared types and constants for the vector rounded-average pipe.
package vavg_pkg;

    typedef enum logic [1:0] {
        ESZ_B   = 2'b00,
        ESZ_H   = 2'b01,
        ESZ_W   = 2'b10,
        ESZ_RSV = 2'b11
    } esz_t;

    localparam int W_B     = 8;
    localparam int W_H     = 16;
    localparam int W_W     = 32;
    localparam int SLICE_W = 32;

endpackage

// File: rtl/vavg_if.sv
// Operand/result handshake bundle between the issue logic and the vavg pipe.
interface vavg_if
    import vavg_pkg::*;
#(
    parameter int VW   = 128,
    parameter int TAGW = 4
);
    logic            in_valid;
    logic            in_ready;
    esz_t            in_esz;
    logic            in_sgn;
    logic [TAGW-1:0] in_tag;
    logic [VW-1:0]   vra;
    logic [VW-1:0]   vrb;
    logic            out_valid;
    logic            out_ready;
    logic [VW-1:0]   vrt;
    logic [TAGW-1:0] out_tag;
    logic            out_err;

    modport master (
        output in_valid, in_esz, in_sgn, in_tag, vra, vrb, out_ready,
        input  in_ready, out_valid, vrt, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_esz, in_sgn, in_tag, vra, vrb, out_ready,
        output in_ready, out_valid, vrt, out_tag, out_err
    );
endinterface

// File: rtl/vavg_slice32.sv
// Combinational rounded average (a + b + 1) >> 1 over one 32-bit slice for any element size.
module vavg_slice32
    import vavg_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  esz_t               esz,
    input  logic               sgn,
    output logic [SLICE_W-1:0] y
);
    logic [SLICE_W-1:0] y_b, y_h, y_w;

    // (ext(a) + ext(b) + 1) >> 1 == (a >>> 1) + (b >>> 1) + (a[0] | b[0]); the true
    // average always fits in w bits, so a w-bit sum needs no guard bits.
    for (genvar i = 0; i < SLICE_W / W_B; i++) begin : g_b
        assign y_b[i*W_B +: W_B] =
            {sgn & a[i*W_B+W_B-1], a[i*W_B+1 +: W_B-1]} +
            {sgn & b[i*W_B+W_B-1], b[i*W_B+1 +: W_B-1]} +
            {{(W_B-1){1'b0}}, a[i*W_B] | b[i*W_B]};
    end

    for (genvar i = 0; i < SLICE_W / W_H; i++) begin : g_h
        assign y_h[i*W_H +: W_H] =
            {sgn & a[i*W_H+W_H-1], a[i*W_H+1 +: W_H-1]} +
            {sgn & b[i*W_H+W_H-1], b[i*W_H+1 +: W_H-1]} +
            {{(W_H-1){1'b0}}, a[i*W_H] | b[i*W_H]};
    end

    assign y_w = {sgn & a[W_W-1], a[W_W-1:1]} +
                 {sgn & b[W_W-1], b[W_W-1:1]} +
                 {{(W_W-1){1'b0}}, a[0] | b[0]};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        y = '0;
        case (esz)
            ESZ_B:   y = y_b;
            ESZ_H:   y = y_h;
            ESZ_W:   y = y_w;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/vavg_pipe.sv
// Two-stage valid/ready vector rounded-average unit: S1 captures operands, S2 holds results.
module vavg_pipe
    import vavg_pkg::*;
#(
    parameter int VW   = 128,
    parameter int TAGW = 4
)(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    vavg_if.slave  bus
);
    localparam int NSLICE = VW / SLICE_W;

    logic            s1_v_q,    s1_v_d;
    logic [VW-1:0]   s1_a_q,    s1_a_d;
    logic [VW-1:0]   s1_b_q,    s1_b_d;
    esz_t            s1_esz_q,  s1_esz_d;
    logic            s1_sgn_q,  s1_sgn_d;
    logic [TAGW-1:0] s1_tag_q,  s1_tag_d;
    logic            s2_v_q,    s2_v_d;
    logic [VW-1:0]   vrt_q,     vrt_d;
    logic [TAGW-1:0] out_tag_q, out_tag_d;
    logic            out_err_q, out_err_d;

    logic            in_ready;
    logic            accept;
    logic            s2_load;
    logic [VW-1:0]   avg;

    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        vavg_slice32 u_slice (
            .a   (s1_a_q[g*SLICE_W +: SLICE_W]),
            .b   (s1_b_q[g*SLICE_W +: SLICE_W]),
            .esz (s1_esz_q),
            .sgn (s1_sgn_q),
            .y   (avg[g*SLICE_W +: SLICE_W])
        );
    end

    // out_ready reaches in_ready combinationally so a full pipe can still accept while draining.
    assign in_ready = !flush && (!s1_v_q || !s2_v_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign s2_load  = s1_v_q && (!s2_v_q || bus.out_ready);

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_esz_d  = s1_esz_q;
        s1_sgn_d  = s1_sgn_q;
        s1_tag_d  = s1_tag_q;
        s2_v_d    = s2_v_q;
        vrt_d     = vrt_q;
        out_tag_d = out_tag_q;
        out_err_d = out_err_q;

        if (flush) begin
            // Only the valid bits drop; data registers keep their contents.
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end else begin
            if (accept) begin
                s1_v_d   = 1'b1;
                s1_a_d   = bus.vra;
                s1_b_d   = bus.vrb;
                s1_esz_d = bus.in_esz;
                s1_sgn_d = bus.in_sgn;
                s1_tag_d = bus.in_tag;
            end else if (s2_load) begin
                s1_v_d = 1'b0;
            end

            if (s2_load) begin
                s2_v_d    = 1'b1;
                vrt_d     = avg;
                out_tag_d = s1_tag_q;
                out_err_d = (s1_esz_q == ESZ_RSV);
            end else if (bus.out_ready) begin
                s2_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_esz_q  <= ESZ_B;
            s1_sgn_q  <= 1'b0;
            s1_tag_q  <= '0;
            s2_v_q    <= 1'b0;
            vrt_q     <= '0;
            out_tag_q <= '0;
            out_err_q <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            s1_v_q    <= s1_v_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_esz_q  <= s1_esz_d;
            s1_sgn_q  <= s1_sgn_d;
            s1_tag_q  <= s1_tag_d;
            s2_v_q    <= s2_v_d;
            vrt_q     <= vrt_d;
            out_tag_q <= out_tag_d;
            out_err_q <= out_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_v_q;
    assign bus.vrt       = vrt_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_err   = out_err_q;
endmodule
